// File: rtl/alu_seq_ctrl_if.sv
// Instruction handshake, ALU drive/return and debug-read bundle for alu_seq_ctrl.
// The slave modport is the controller's view; master is the source/ALU side.
interface alu_seq_ctrl_if;
    logic [9:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       done;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic       alu_l;
    logic [3:0] alu_r;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_sign;
    logic [2:0] flags;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;

    modport slave (
        input  instr, instr_valid, alu_r, alu_zero, alu_carry, alu_sign, rd_addr,
        output instr_ready, done, alu_a, alu_b, alu_op, alu_l, flags, rd_data
    );

    modport master (
        output instr, instr_valid, alu_r, alu_zero, alu_carry, alu_sign, rd_addr,
        input  instr_ready, done, alu_a, alu_b, alu_op, alu_l, flags, rd_data
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// IDLE/EXEC/WB sequencer for an external 4-bit ALU with a 4x4 register bank and flags.
// Optional macro ALU_SEQ_BYPASS_EN lets WB accept the next instruction (2-cycle throughput).
module alu_seq_ctrl #(
    parameter logic [3:0] REG_INIT = 4'b0000
) (
    input  logic         clk,
    input  logic         reset,
    alu_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [9:0] r_instr;
    logic [3:0] r_regs [4];
    logic [2:0] r_flags;

    logic       w_ready;
    logic       w_done;
    logic       w_accept;
    logic       w_wr_en;
    logic [3:0] w_wr_data;
    logic [3:0] w_wr_sel;
    logic [3:0] w_alu_a;
    logic [3:0] w_alu_b;
    logic [1:0] w_alu_op;
    logic       w_alu_l;

    // Fields of the latched instruction; imm overlaps ra/rb.
    logic       w_ldi;
    logic       w_l;
    logic [1:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_ra;
    logic [1:0] w_rb;
    logic [3:0] w_imm;

    assign w_ldi = r_instr[9];
    assign w_l   = r_instr[8];
    assign w_op  = r_instr[7:6];
    assign w_rd  = r_instr[5:4];
    assign w_ra  = r_instr[3:2];
    assign w_rb  = r_instr[1:0];
    assign w_imm = r_instr[3:0];

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        w_wr_en      = 1'b0;
        w_alu_a      = 4'd0;
        w_alu_b      = 4'd0;
        w_alu_op     = 2'd0;
        w_alu_l      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                w_wr_en = 1'b1;
                if (!w_ldi) begin
                    w_alu_a  = r_regs[w_ra];
                    w_alu_b  = r_regs[w_rb];
                    w_alu_op = w_op;
                    w_alu_l  = w_l;
                end
                w_state_next = WB;
            end
            WB: begin
                w_done = 1'b1;
`ifdef ALU_SEQ_BYPASS_EN
                w_ready      = 1'b1;
                w_state_next = bus.instr_valid ? EXEC : IDLE;
`else
                w_state_next = IDLE;
`endif
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_accept  = w_ready & bus.instr_valid;
    assign w_wr_data = w_ldi ? w_imm : bus.alu_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_instr <= 10'd0;
            r_flags <= 3'b000;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_instr <= bus.instr;
            end
            if (w_wr_en && !w_ldi) begin
                r_flags <= {bus.alu_zero, bus.alu_carry, bus.alu_sign};
            end
        end
    end

    // One-hot write select per bank entry.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
            assign w_wr_sel[gi] = w_wr_en && (w_rd == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                r_regs[i] <= REG_INIT;
            end else if (w_wr_sel[i]) begin
                r_regs[i] <= w_wr_data;
            end
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.done        = w_done;
    assign bus.alu_a       = w_alu_a;
    assign bus.alu_b       = w_alu_b;
    assign bus.alu_op      = w_alu_op;
    assign bus.alu_l       = w_alu_l;
    assign bus.flags       = r_flags;
    assign bus.rd_data     = r_regs[bus.rd_addr];

endmodule
